char_rx_fifo: RTL and testbench
===============================

Name: char_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART character receiver.
- Captures each byte when the receiver's one-cycle finished pulse fires and holds up to DEPTH bytes.
- Presents the bytes first-word-fall-through on a valid/ready interface to the consumer logic.
- Detects and flags overrun when a byte arrives while the buffer is full and no pop happens that cycle.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clk  input  1  system clock, 23.04 MHz domain shared with the receiver.
- i_rst  input  1  asynchronous active-low reset.
- i_char  input  8  received byte; valid only in the cycle i_finished=1.
- i_finished  input  1  one-cycle push strobe from the receiver.
- o_data  output  8  head-of-queue byte; 8'd0 when empty.
- o_valid  output  1  head byte available (=!o_empty).
- i_ready  input  1  consumer accepts head; pop occurs when o_valid&&i_ready.
- o_count  output  AW+1  number of stored bytes, 0..DEPTH.
- o_empty  output  1  o_count==0.
- o_full  output  1  o_count==DEPTH.
- o_overrun  output  1  sticky: at least one byte was dropped.
- i_clr_overrun  input  1  synchronous clear of o_overrun.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst; all registers are cleared on its falling edge, independent of the clock.
- Reset values: wr_ptr=0, rd_ptr=0, o_count=0, o_empty=1, o_full=0, o_valid=0, o_overrun=0, o_data=0. Storage array is not reset.
- Storage: DEPTH x 8 register array.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0. o_count is kept as a separate AW+1-bit register.
- push = i_finished && (!o_full || pop).
- pop = o_valid && i_ready.
- Push writes mem[wr_ptr] <= i_char and increments wr_ptr on the same edge.
- Pop increments rd_ptr.
- Count update:
  - push&&!pop: +1
  - pop&&!push: -1
  - both: unchanged
  - neither: unchanged
- Latency: a byte pushed at edge N gives o_valid=1 and o_data=that byte in the cycle after edge N. There is no bypass when empty: i_finished while empty does not make o_valid=1 in the same cycle.
- o_data is combinational from mem[rd_ptr], gated to 0 when o_empty=1. o_data must stay stable while o_valid=1 and i_ready=0.
- Full with simultaneous push and pop: both succeed; count stays DEPTH; no overrun.
- Full with push and no pop: byte is discarded; pointers and count unchanged; o_overrun <= 1 on that edge.
- Empty with i_ready=1: no pop; rd_ptr and count unchanged; no underflow.
- o_overrun is sticky until i_clr_overrun=1. If a clear and a new overrun occur in the same cycle, set wins and o_overrun stays 1.
- i_finished is edge-agnostic: every cycle it is high counts as one push. The receiver guarantees single-cycle pulses.
- Reset mid-operation: all stored bytes are lost and outputs return to reset values immediately (asynchronous).
- o_full, o_empty and o_valid are decoded from the registered o_count; there is no combinational path from i_finished to any status output.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 with i_ready=0 → o_count=3; o_data=0x41 one cycle after the first push; o_empty=0.
- Hold i_ready=1 after three pushes → o_data reads 0x41, 0x42, 0x43 on consecutive cycles; then o_valid=0, o_data=0, o_count=0.
- Push 16 bytes 0x00..0x0F with i_ready=0 → o_full=1; push 0xAA → dropped, o_overrun=1, o_count=16; drain reads 0x00..0x0F with no 0xAA.
- When full, push 0x55 and pop in the same cycle → o_count stays 16, o_overrun stays 0; the final byte drained is 0x55.
- Set o_overrun, then assert i_clr_overrun together with a full-buffer drop → o_overrun=1; a clear alone on the next cycle → o_overrun=0.
- Push 10 bytes, assert i_rst=0 mid-stream asynchronously (between clock edges) → o_count=0, o_empty=1, o_valid=0, o_overrun=0 before the next clock edge.
- Wrap-around: run 40 push/pop pairs with random gaps → output sequence matches input order, o_count never exceeds 16, and no spurious overrun.

Source files
------------

// File: rtl/char_rx_fifo.sv
// Receive-side byte buffer behind the UART character receiver.
// Bytes are captured on the receiver's one-cycle finished strobe and
// presented first-word-fall-through on a valid/ready interface. A push
// into a full buffer with no simultaneous pop is dropped and flagged
// on a sticky overrun bit.
module char_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_char,
    input  logic          i_finished,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overrun,
    input  logic          i_clr_overrun
);

    localparam logic [AW:0]   LP_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE    = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Status flags come only from the registered count, so the receiver
    // strobe never reaches a status output combinationally.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_FULL_COUNT);

    // A full buffer still accepts a byte when the head leaves on the same edge.
    assign w_pop  = !w_empty && i_ready;
    assign w_push = i_finished && (!w_full || w_pop);
    assign w_drop = i_finished && w_full && !w_pop;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_char;
        end
    end

    // Pointers wrap naturally at DEPTH because they are exactly AW bits wide.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
        end
    end

    // Occupancy count: only a lone push or a lone pop changes it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_COUNT_ONE;
                2'b01:   r_count <= r_count - LP_COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Head byte is read straight from the array and forced to zero when empty.
    always_comb begin
        o_data = 8'd0;
        if (!w_empty) begin
            o_data = r_mem[r_rd_ptr];
        end
    end

    assign o_valid   = !w_empty;
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_char_rx_fifo.sv
// Directed testbench for char_rx_fifo (DEPTH = 16).
module tb_char_rx_fifo;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_char;
    logic       i_finished;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_overrun;
    logic       i_clr_overrun;

    int checks = 0;
    int errors = 0;

    char_rx_fifo #(.DEPTH(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_char       (i_char),
        .i_finished   (i_finished),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_count      (o_count),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_overrun    (o_overrun),
        .i_clr_overrun(i_clr_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_char     = b;
        i_finished = 1'b1;
        tick();
        i_finished = 1'b0;
        $display("push %02h count=%0d overrun=%0b", b, o_count, o_overrun);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", o_empty); end
        checks++; if (o_valid !== 1'b0 || o_full !== 1'b0) begin errors++; $display("FAIL reset_valid_full got=%0b%0b exp=00", o_valid, o_full); end
        checks++; if (o_overrun !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL reset_ovr_data got=%0b/%02h exp=0/00", o_overrun, o_data); end
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_release_empty got=%0b exp=1", o_empty); end
        $display("reset done");
    endtask

    task automatic test_basic_push();
        i_ready    = 1'b0;
        i_char     = 8'h41;
        i_finished = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got=%0b exp=0", o_valid); end
        tick();
        i_finished = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h41) begin errors++; $display("FAIL first_latency got=%0b/%02h exp=1/41", o_valid, o_data); end
        push_byte(8'h42);
        push_byte(8'h43);
        checks++; if (o_count !== 5'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", o_count); end
        checks++; if (o_data !== 8'h41 || o_empty !== 1'b0) begin errors++; $display("FAIL basic_head got=%02h/%0b exp=41/0", o_data, o_empty); end
    endtask

    task automatic test_drain_three();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data !== exp_b[i]) begin errors++; $display("FAIL drain3_byte%0d got=%02h exp=%02h", i, o_data, exp_b[i]); end
            $display("pop %02h", o_data);
            tick();
        end
        checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_count !== 5'd0) begin errors++; $display("FAIL drain3_empty got=%0b/%02h/%0d exp=0/00/0", o_valid, o_data, o_count); end
        tick();
        checks++; if (o_count !== 5'd0) begin errors++; $display("FAIL no_underflow got=%0d exp=0", o_count); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        checks++; if (o_full !== 1'b1 || o_count !== 5'd16) begin errors++; $display("FAIL fill_full got=%0b/%0d exp=1/16", o_full, o_count); end
        push_byte(8'hAA);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun got=%0b exp=1", o_overrun); end
        checks++; if (o_count !== 5'd16 || o_data !== 8'h00) begin errors++; $display("FAIL drop_state got=%0d/%02h exp=16/00", o_count, o_data); end
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (o_data !== 8'(i)) begin errors++; $display("FAIL drain16_byte%0d got=%02h exp=%02h", i, o_data, 8'(i)); end
            tick();
        end
        i_ready = 1'b0;
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain16_empty got=%0b exp=1", o_empty); end
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun got=%0b exp=0", o_overrun); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
        i_char     = 8'h55;
        i_finished = 1'b1;
        i_ready    = 1'b1;
        tick();
        i_finished = 1'b0;
        i_ready    = 1'b0;
        checks++; if (o_count !== 5'd16 || o_full !== 1'b1) begin errors++; $display("FAIL fullpp_count got=%0d/%0b exp=16/1", o_count, o_full); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL fullpp_overrun got=%0b exp=0", o_overrun); end
        checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL fullpp_head got=%02h exp=11", o_data); end
        i_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++; if (o_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL fullpp_byte%0d got=%02h exp=%02h", i, o_data, 8'(8'h10 + i)); end
            tick();
        end
        checks++; if (o_data !== 8'h55) begin errors++; $display("FAIL fullpp_last got=%02h exp=55", o_data); end
        tick();
        i_ready = 1'b0;
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty got=%0b exp=1", o_empty); end
    endtask

    task automatic test_clr_vs_set();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        push_byte(8'hEE);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL cvs_first_set got=%0b exp=1", o_overrun); end
        i_clr_overrun = 1'b1;
        push_byte(8'hEF);
        i_clr_overrun = 1'b0;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL cvs_set_wins got=%0b exp=1", o_overrun); end
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL cvs_clear got=%0b exp=0", o_overrun); end
        checks++; if (o_count !== 5'd16 || o_data !== 8'h20) begin errors++; $display("FAIL cvs_state got=%0d/%02h exp=16/20", o_count, o_data); end
        i_ready = 1'b1;
        repeat (16) tick();
        i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
        push_byte(8'hBB);
        i_ready = 1'b1;
        repeat (6) tick();
        i_ready = 1'b0;
        checks++; if (o_count !== 5'd10 || o_overrun !== 1'b1) begin errors++; $display("FAIL pre_reset got=%0d/%0b exp=10/1", o_count, o_overrun); end
        #2;
        i_rst = 1'b0;
        #1;
        checks++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL async_count got=%0d/%0b exp=0/1", o_count, o_empty); end
        checks++; if (o_valid !== 1'b0 || o_overrun !== 1'b0 || o_data !== 8'h00) begin errors++; $display("FAIL async_outs got=%0b/%0b/%02h exp=0/0/00", o_valid, o_overrun, o_data); end
        @(negedge i_clk);
        i_rst = 1'b1;
        tick();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL async_release got=%0b exp=1", o_empty); end
        $display("async reset done");
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        int pushed = 0;
        int popped = 0;
        int cycles = 0;
        logic do_push;
        logic [7:0] b;
        while ((pushed < 40 || q.size() != 0) && cycles < 3000) begin
            do_push = (pushed < 40) && (q.size() < 16) && ($urandom_range(0, 2) == 0);
            b = 8'(pushed * 13 + 5);
            i_char     = b;
            i_finished = do_push;
            i_ready    = ($urandom_range(0, 1) == 1);
            #1;
            checks++; if (o_valid !== (q.size() != 0) || o_count !== 5'(q.size())) begin errors++; $display("FAIL wrap_status got=%0b/%0d exp=%0b/%0d", o_valid, o_count, q.size() != 0, q.size()); end
            checks++; if (o_overrun !== 1'b0 || o_count > 5'd16) begin errors++; $display("FAIL wrap_overrun got=%0b/%0d exp=0/<=16", o_overrun, o_count); end
            if (i_ready && q.size() != 0) begin
                checks++; if (o_data !== q[0]) begin errors++; $display("FAIL wrap_data%0d got=%02h exp=%02h", popped, o_data, q[0]); end
                $display("pop %02h", q[0]);
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(b);
                pushed++;
                $display("push %02h", b);
            end
            @(posedge i_clk);
            #1;
            i_finished = 1'b0;
            i_ready    = 1'b0;
            cycles++;
        end
        checks++; if (popped != 40) begin errors++; $display("FAIL wrap_done got=%0d exp=40", popped); end
    endtask

    initial begin
        i_rst         = 1'b0;
        i_char        = 8'h00;
        i_finished    = 1'b0;
        i_ready       = 1'b0;
        i_clr_overrun = 1'b0;
        test_reset();
        test_basic_push();
        test_drain_three();
        test_full_overrun();
        test_full_push_pop();
        test_clr_vs_set();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
